// File: rtl/nbit_counter_pkg.sv
// Shared state encoding for the N-bit up/down counter family.
package nbit_counter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/nbit_upcounter_ctrl_if.sv
// Control/status bundle of the up counter.
// master drives the controls, slave is the counter.
interface nbit_upcounter_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, load, load_val, limit,
        input  count, busy, tc, done
    );

    modport slave (
        input  start, stop, load, load_val, limit,
        output count, busy, tc, done
    );

endinterface

// File: rtl/upcount_prescaler.sv
// Tick generator: one tick every PRESCALE enabled clocks.
module upcount_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/nbit_upcounter_ctrl.sv
// N-bit up counter with start/stop/hold FSM, load and terminal value.
// UPCOUNT_PRESCALE_EN: advance only every PRESCALE clocks while running.
module nbit_upcounter_ctrl
    import nbit_counter_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int MODE_WRAP = 1,
    parameter int PRESCALE  = 4
) (
    input  logic clk,
    input  logic rst,
    nbit_upcounter_ctrl_if.slave bus
);
    localparam logic WRAP = (MODE_WRAP != 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;
    logic             tick;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] adv;
    logic             entry_hit;

`ifdef UPCOUNT_PRESCALE_EN
    upcount_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_psc (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != RUN),
        .en   (state_q == RUN),
        .tick (tick)
    );
`else
    assign tick = (PRESCALE >= 1);
`endif

    assign start_val = bus.load ? bus.load_val : '0;
    assign entry_hit = (start_val == bus.limit);
    // At the terminal value the next advance rolls over to zero.
    assign adv = (count_q == bus.limit) ? '0 : count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    count_d = start_val;
                    tc_d    = entry_hit;
                    state_d = (!WRAP && entry_hit) ? DONE : RUN;
                end else if (bus.load) begin
                    count_d = bus.load_val;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = HOLD;
                end else if (tick) begin
                    count_d = adv;
                    tc_d    = (adv == bus.limit);
                    if (!WRAP && adv == bus.limit) begin
                        state_d = DONE;
                    end
                end
            end
            HOLD: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.start) begin
                    state_d = RUN;
                    if (bus.load) begin
                        count_d = bus.load_val;
                    end
                end else if (bus.load) begin
                    count_d = bus.load_val;
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.start) begin
                    count_d = start_val;
                    tc_d    = entry_hit;
                    state_d = (!WRAP && entry_hit) ? DONE : RUN;
                end else if (bus.load) begin
                    count_d = bus.load_val;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == RUN);
            done_q  <= !WRAP && (state_d == DONE);
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_nbit_upcounter_ctrl.sv
// Bench for nbit_upcounter_ctrl: wrap and stop-at-limit instances
// driven in parallel, checked against a behavioural model.
module tb_nbit_upcounter_ctrl;
    localparam int W = 5;
    localparam int M = 32;
`ifdef UPCOUNT_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic s, p, l;
    logic [W-1:0] lv, lim;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model state per instance: 0 stop-at-limit, 1 wrap
    // st: 0 idle, 1 running, 2 held, 3 finished
    int st[2];
    int cnt[2];
    int ps[2];
    bit tcm[2];

    always #5 clk = ~clk;

    nbit_upcounter_ctrl_if #(.WIDTH(W)) b1 ();
    nbit_upcounter_ctrl_if #(.WIDTH(W)) b0 ();

    assign b1.start = s;
    assign b1.stop = p;
    assign b1.load = l;
    assign b1.load_val = lv;
    assign b1.limit = lim;
    assign b0.start = s;
    assign b0.stop = p;
    assign b0.load = l;
    assign b0.load_val = lv;
    assign b0.limit = lim;

    nbit_upcounter_ctrl #(
        .WIDTH(W), .MODE_WRAP(1), .PRESCALE(PS)
    ) u_wrap (
        .clk(clk), .rst(rst), .bus(b1)
    );

    nbit_upcounter_ctrl #(
        .WIDTH(W), .MODE_WRAP(0), .PRESCALE(PS)
    ) u_stop (
        .clk(clk), .rst(rst), .bus(b0)
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            st[d] = 0;
            cnt[d] = 0;
            ps[d] = 0;
            tcm[d] = 0;
        end
    endtask

    task automatic enter(input int d, input int sv);
        cnt[d] = sv;
        ps[d] = 0;
        tcm[d] = (sv == int'(lim));
        st[d] = (d == 0 && sv == int'(lim)) ? 3 : 1;
    endtask

    task automatic model_step();
        int sv;
        int nx;
        sv = l ? int'(lv) : 0;
        for (int d = 0; d < 2; d++) begin
            tcm[d] = 0;
            case (st[d])
                0: begin
                    if (s && !p) enter(d, sv);
                    else if (l) cnt[d] = int'(lv);
                end
                1: begin
                    if (p) begin
                        st[d] = 2;
                    end else if (ps[d] == PS - 1) begin
                        ps[d] = 0;
                        nx = (cnt[d] == int'(lim)) ? 0 : (cnt[d] + 1) % M;
                        cnt[d] = nx;
                        if (nx == int'(lim)) begin
                            tcm[d] = 1;
                            if (d == 0) st[d] = 3;
                        end
                    end else begin
                        ps[d]++;
                    end
                end
                2: begin
                    if (p) begin
                        st[d] = 0;
                        cnt[d] = 0;
                    end else if (s) begin
                        st[d] = 1;
                        ps[d] = 0;
                        if (l) cnt[d] = int'(lv);
                    end else if (l) begin
                        cnt[d] = int'(lv);
                    end
                end
                default: begin
                    if (p) begin
                        st[d] = 0;
                        cnt[d] = 0;
                    end else if (s) begin
                        enter(d, sv);
                    end else if (l) begin
                        cnt[d] = int'(lv);
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        int gc, gb, gt, gd;
        for (int d = 0; d < 2; d++) begin
            gc = (d == 1) ? int'(b1.count) : int'(b0.count);
            gb = (d == 1) ? int'(b1.busy) : int'(b0.busy);
            gt = (d == 1) ? int'(b1.tc) : int'(b0.tc);
            gd = (d == 1) ? int'(b1.done) : int'(b0.done);
            checks++;
            if (gc !== cnt[d] || gb !== int'(st[d] == 1) ||
                gt !== int'(tcm[d]) || gd !== int'(st[d] == 3)) begin
                failures++;
                $display("FAIL model%0d cyc=%0d got c=%0d b=%0d t=%0d d=%0d want c=%0d b=%0d t=%0d d=%0d",
                         d, cyc, gc, gb, gt, gd, cnt[d],
                         int'(st[d] == 1), int'(tcm[d]), int'(st[d] == 3));
            end
        end
    endtask

    task automatic lit(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        lit("rst_async_c1", int'(b1.count), 0);
        lit("rst_async_b1", int'(b1.busy), 0);
        lit("rst_async_t1", int'(b1.tc), 0);
        lit("rst_async_c0", int'(b0.count), 0);
        lit("rst_async_d0", int'(b0.done), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        s = 0; p = 0; l = 0; lv = '0; lim = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        lit("reset_count", int'(b1.count), 0);
        lit("reset_busy", int'(b1.busy), 0);
        rst = 1'b0;

        // reset mid-count at 13
        lim = 5'd31;
        s = 1; step(); s = 0;
        repeat (13 * PS) step();
        lit("pre_rst_13", int'(b1.count), 13);
        mid_reset();
        step();
        lit("post_rst_idle", int'(b1.busy), 0);
        lit("post_rst_cnt", int'(b1.count), 0);

        // limit 7 from 0
        lim = 5'd7;
        s = 1; step(); s = 0;
        lit("l7_entry_c", int'(b1.count), 0);
        lit("l7_entry_b", int'(b1.busy), 1);
        repeat (7 * PS) step();
        lit("l7_top_c", int'(b1.count), 7);
        lit("l7_top_tc", int'(b1.tc), 1);
        lit("l7_done0", int'(b0.done), 1);
        lit("l7_busy0", int'(b0.busy), 0);
        lit("l7_cnt0", int'(b0.count), 7);
        repeat (PS) step();
        lit("l7_wrap_c", int'(b1.count), 0);
        lit("l7_wrap_tc", int'(b1.tc), 0);
        lit("l7_wrap_b", int'(b1.busy), 1);
        lit("l7_held0", int'(b0.count), 7);

        // restart from done
        s = 1; step(); s = 0;
        lit("restart_c0", int'(b0.count), 0);
        lit("restart_d0", int'(b0.done), 0);
        lit("restart_b0", int'(b0.busy), 1);
        p = 1; step(); step(); p = 0;

        // hold, load, resume, start&stop
        lim = 5'd31;
        s = 1; step(); s = 0;
        repeat (9 * PS) step();
        lit("run9", int'(b1.count), 9);
        l = 1; lv = 5'd20;
        repeat (PS) step();
        l = 0;
        lit("run_load_ign", int'(b1.count), 10);
        p = 1; step(); p = 0;
        lit("hold_busy", int'(b1.busy), 0);
        repeat (4) step();
        lit("hold_frozen", int'(b1.count), 10);
        l = 1; step(); l = 0;
        lit("hold_load", int'(b1.count), 20);
        s = 1; step(); s = 0;
        lit("resume_b", int'(b1.busy), 1);
        repeat (PS) step();
        lit("resume_21", int'(b1.count), 21);
        s = 1; p = 1; step(); s = 0; p = 0;
        lit("stop_wins_b", int'(b1.busy), 0);
        lit("stop_wins_c", int'(b1.count), 21);
        p = 1; step(); p = 0;

        // load+start above limit, wrap through zero
        lim = 5'd2; lv = 5'd30;
        l = 1; s = 1; step(); l = 0; s = 0;
        lit("ld30", int'(b1.count), 30);
        repeat (PS) step();
        lit("ld31", int'(b1.count), 31);
        repeat (PS) step();
        lit("ld_wrap0", int'(b1.count), 0);
        lit("ld_wrap_tc", int'(b1.tc), 0);
        repeat (2 * PS) step();
        lit("ld_lim2", int'(b1.count), 2);
        lit("ld_lim2_tc", int'(b1.tc), 1);
        lit("ld_done0", int'(b0.done), 1);
        step();
        lit("tc_one_wide", int'(b1.tc), 0);

        // limit 0: tc on entry
        lim = 5'd0;
        p = 1; step(); step(); p = 0;
        s = 1; step(); s = 0;
        lit("l0_entry_tc", int'(b1.tc), 1);
        lit("l0_entry_b", int'(b1.busy), 1);
        lit("l0_done0", int'(b0.done), 1);
        lit("l0_tc0", int'(b0.tc), 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                s = 0; p = 0; l = 0;
                mid_reset();
                check_all();
            end else begin
                s = ($urandom_range(0, 7) == 0);
                p = ($urandom_range(0, 11) == 0);
                l = ($urandom_range(0, 9) == 0);
                lv = W'($urandom);
                if ($urandom_range(0, 39) == 0) lim = W'($urandom);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
